id_regfile_scheduler: RTL and testbench

- Sequences the ID-stage register file: scoreboards destination registers still in flight and stalls issue on RAW/WAW hazards.
- Arbitrates the single register-file write port between pipeline writeback (WB) and the multi-cycle unit (MC, mult/div/load).
- Drives the register file's RegWrite/write_register/write_data from registered outputs.
- Sits between the ID decode logic, the WB stage, the MC unit and the register file.

---
 rtl/mips_pkg.sv | 16 +
 rtl/id_regfile_scheduler_if.sv | 47 ++++
 rtl/regwrite_arbiter.sv | 75 +++++++
 rtl/id_regfile_scheduler.sv | 84 ++++++++
 tb/tb_id_regfile_scheduler.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants and grant-source encoding for the ID-stage
// register-file scheduler slice.
package mips_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_MC
    } gnt_e;

endpackage

// File: rtl/id_regfile_scheduler_if.sv
// Issue, writeback, multi-cycle and register-file signals of the
// scheduler; master is the pipeline side, slave is the scheduler.
interface id_regfile_scheduler_if;
    import mips_pkg::*;

    logic              issue_valid;
    logic [REG_W-1:0]  issue_rs;
    logic [REG_W-1:0]  issue_rt;
    logic              issue_uses_rt;
    logic              issue_writes;
    logic [REG_W-1:0]  issue_dest;
    logic              issue_long;
    logic              stall;

    logic              wb_valid;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              wb_hold;

    logic              mc_valid;
    logic [REG_W-1:0]  mc_reg;
    logic [DATA_W-1:0] mc_data;
    logic              mc_ready;

    logic              RegWrite;
    logic [REG_W-1:0]  write_register;
    logic [DATA_W-1:0] write_data;

    modport master (
        output issue_valid, issue_rs, issue_rt, issue_uses_rt,
        output issue_writes, issue_dest, issue_long,
        output wb_valid, wb_reg, wb_data,
        output mc_valid, mc_reg, mc_data,
        input  stall, wb_hold, mc_ready,
        input  RegWrite, write_register, write_data
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_uses_rt,
        input  issue_writes, issue_dest, issue_long,
        input  wb_valid, wb_reg, wb_data,
        input  mc_valid, mc_reg, mc_data,
        output stall, wb_hold, mc_ready,
        output RegWrite, write_register, write_data
    );

endinterface

// File: rtl/regwrite_arbiter.sv
// Arbitrates the single register-file write port between WB and the
// multi-cycle unit, with starvation relief, and registers the write.
module regwrite_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mc_valid,
    input  logic [REG_W-1:0]  mc_reg,
    input  logic [DATA_W-1:0] mc_data,
    output gnt_e              gnt,
    output logic              wb_hold,
    output logic              mc_ready,
    output logic              reg_write,
    output logic [REG_W-1:0]  write_register,
    output logic [DATA_W-1:0] write_data
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic          mc_force;

    assign mc_force = mc_valid && (starve_cnt == SW'(STARVE_LIMIT));

    always_comb begin
        gnt = GNT_NONE;
        if (reset)
            gnt = GNT_NONE;
        else if (mc_force)
            gnt = GNT_MC;
        else if (wb_valid)
            gnt = GNT_WB;
        else if (mc_valid)
            gnt = GNT_MC;
    end

    assign mc_ready = (gnt == GNT_MC);
    assign wb_hold  = wb_valid && (gnt == GNT_MC);

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt     <= '0;
            reg_write      <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
        end else begin
            // the forced grant at the limit keeps this from wrapping
            if (mc_valid && gnt != GNT_MC)
                starve_cnt <= starve_cnt + 1'b1;
            else
                starve_cnt <= '0;

            unique case (gnt)
                GNT_WB: begin
                    reg_write      <= (wb_reg != ZERO_REG);
                    write_register <= wb_reg;
                    write_data     <= wb_data;
                end
                GNT_MC: begin
                    reg_write      <= (mc_reg != ZERO_REG);
                    write_register <= mc_reg;
                    write_data     <= mc_data;
                end
                default: reg_write <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/id_regfile_scheduler.sv
// ID-stage register-file scheduler: destination scoreboard with RAW/WAW
// and long-op capacity stalls, plus the write-port arbiter.
module id_regfile_scheduler
    import mips_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int LONG_MAX     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic               clk,
    input  logic               reset,
    id_regfile_scheduler_if.slave rf
);

    localparam int LW = $clog2(LONG_MAX + 1);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] pending_d;
    logic [LW-1:0]       long_cnt;

    logic raw, waw, full, accept, inc, dec;
    gnt_e gnt;

    assign raw  = pending[rf.issue_rs] |
                  (rf.issue_uses_rt & pending[rf.issue_rt]);
    assign waw  = rf.issue_writes & pending[rf.issue_dest];
    assign full = rf.issue_long & rf.issue_writes &
                  (long_cnt == LW'(LONG_MAX));

    assign rf.stall = !reset & rf.issue_valid & (raw | waw | full);
    assign accept   = !reset & rf.issue_valid & !rf.stall;

    assign inc = accept & rf.issue_long;
    assign dec = (gnt == GNT_MC) && (long_cnt != '0);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (accept && rf.issue_writes && rf.issue_dest != ZERO_REG)
            set_vec[rf.issue_dest] = 1'b1;
        if (gnt == GNT_WB)
            clr_vec[rf.wb_reg] = 1'b1;
        if (gnt == GNT_MC)
            clr_vec[rf.mc_reg] = 1'b1;
    end

    // set is applied after clear so a same-cycle issue wins
    assign pending_d = (pending & ~clr_vec) | set_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            long_cnt <= '0;
        end else begin
            pending <= {pending_d[NUM_REGS-1:1], 1'b0};
            if (inc && !dec && long_cnt != LW'(LONG_MAX))
                long_cnt <= long_cnt + 1'b1;
            else if (dec && !inc)
                long_cnt <= long_cnt - 1'b1;
        end
    end

    regwrite_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk            (clk),
        .reset          (reset),
        .wb_valid       (rf.wb_valid),
        .wb_reg         (rf.wb_reg),
        .wb_data        (rf.wb_data),
        .mc_valid       (rf.mc_valid),
        .mc_reg         (rf.mc_reg),
        .mc_data        (rf.mc_data),
        .gnt            (gnt),
        .wb_hold        (rf.wb_hold),
        .mc_ready       (rf.mc_ready),
        .reg_write      (rf.RegWrite),
        .write_register (rf.write_register),
        .write_data     (rf.write_data)
    );

endmodule

// File: tb/tb_id_regfile_scheduler.sv
// Directed plus randomized bench for id_regfile_scheduler against a
// behavioural scoreboard/arbiter model.
module tb_id_regfile_scheduler;

    localparam int LMAX  = 4;
    localparam int SLIM  = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    id_regfile_scheduler_if bus ();

    id_regfile_scheduler dut (
        .clk   (clk),
        .reset (rst),
        .rf    (bus.slave)
    );

    always #5 clk = ~clk;

    // reference state
    bit          pend [32];
    int          lc;
    int          starve;
    bit          rw_m;
    logic [4:0]  wr_m;
    logic [31:0] wd_m;
    bit          mcg_last;
    bit          wbh_last;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        bus.issue_valid   = 0;
        bus.issue_rs      = 0;
        bus.issue_rt      = 0;
        bus.issue_uses_rt = 0;
        bus.issue_writes  = 0;
        bus.issue_dest    = 0;
        bus.issue_long    = 0;
        bus.wb_valid      = 0;
        bus.wb_reg        = 0;
        bus.wb_data       = 0;
        bus.mc_valid      = 0;
        bus.mc_reg        = 0;
        bus.mc_data       = 0;
    endtask

    task automatic issue(input bit v, input int rs, input int rt,
                         input bit ut, input bit w, input int d,
                         input bit l);
        bus.issue_valid   = v;
        bus.issue_rs      = 5'(rs);
        bus.issue_rt      = 5'(rt);
        bus.issue_uses_rt = ut;
        bus.issue_writes  = w;
        bus.issue_dest    = 5'(d);
        bus.issue_long    = l;
    endtask

    task automatic wb(input bit v, input int r, input int d);
        bus.wb_valid = v;
        bus.wb_reg   = 5'(r);
        bus.wb_data  = 32'(d);
    endtask

    task automatic mc(input bit v, input int r, input int d);
        bus.mc_valid = v;
        bus.mc_reg   = 5'(r);
        bus.mc_data  = 32'(d);
    endtask

    // one clock: check combinational outputs mid-cycle, then registered
    task automatic cycle();
        bit hz, st, acc, mcg, wbg, inc, dec;
        int rs, rt, ds;
        @(negedge clk);
        rs = int'(bus.issue_rs);
        rt = int'(bus.issue_rt);
        ds = int'(bus.issue_dest);
        hz = pend[rs] || (bus.issue_uses_rt && pend[rt]) ||
             (bus.issue_writes && pend[ds]) ||
             (bus.issue_long && bus.issue_writes && lc == LMAX);
        st  = !rst && bus.issue_valid && hz;
        acc = !rst && bus.issue_valid && !hz;
        mcg = !rst && bus.mc_valid && (!bus.wb_valid || starve == SLIM);
        wbg = !rst && bus.wb_valid && !mcg;
        chk("stall", bus.stall, st);
        chk("mc_ready", bus.mc_ready, mcg);
        chk("wb_hold", bus.wb_hold, bus.wb_valid && mcg);
        mcg_last = mcg;
        wbh_last = bus.wb_valid && mcg;
        @(posedge clk);
        #1;
        if (rst) begin
            foreach (pend[i]) pend[i] = 0;
            lc = 0;
            starve = 0;
            rw_m = 0;
            wr_m = 0;
            wd_m = 0;
        end else begin
            if (wbg) pend[bus.wb_reg] = 0;
            if (mcg) pend[bus.mc_reg] = 0;
            if (acc && bus.issue_writes && ds != 0) pend[ds] = 1;
            inc = acc && bus.issue_long;
            dec = mcg && lc > 0;
            lc = lc + int'(inc) - int'(dec);
            if (lc > LMAX) lc = LMAX;
            starve = (bus.mc_valid && !mcg) ? starve + 1 : 0;
            rw_m = 0;
            if (wbg) begin
                rw_m = bus.wb_reg != 0;
                wr_m = bus.wb_reg;
                wd_m = bus.wb_data;
            end else if (mcg) begin
                rw_m = bus.mc_reg != 0;
                wr_m = bus.mc_reg;
                wd_m = bus.mc_data;
            end
        end
        chk("RegWrite", bus.RegWrite, rw_m);
        if (rw_m) begin
            chk("write_register", bus.write_register, wr_m);
            chk("write_data", bus.write_data, wd_m);
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        bit mc_on;
        total = 0;
        bad   = 0;
        clk   = 0;
        mc_on = 0;
        idle();
        rst = 1;
        cycle();
        chk("rst_wreg", bus.write_register, 0);
        chk("rst_wdata", bus.write_data, 0);
        rst = 0;

        // RAW on a short op, cleared by WB
        issue(1, 0, 0, 0, 1, 8, 0); cycle();
        issue(1, 8, 0, 0, 0, 0, 0); cycle();
        wb(1, 8, 'hAB);             cycle();
        wb(0, 0, 0);                cycle();
        chk("raw_release", bus.stall, 0);

        // dest 0 never pending; WB to reg 0 does not write
        idle(); issue(1, 0, 0, 0, 1, 0, 0); cycle();
        issue(1, 0, 0, 1, 1, 0, 0);         cycle();
        idle(); wb(1, 0, 'h55);             cycle();
        idle();                             cycle();

        // long-op capacity
        for (int i = 1; i <= 4; i++) begin
            issue(1, 0, 0, 0, 1, i, 1); cycle();
        end
        issue(1, 0, 0, 0, 1, 9, 1); mc(1, 1, 'h1111); cycle();
        mc(0, 0, 0);                                  cycle();
        issue(1, 0, 0, 0, 1, 10, 1);                  cycle();
        chk("full_stall", bus.stall, 1);

        // starvation relief
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            issue(1, 0, 0, 0, 1, 11 + i, 1); cycle();
        end
        idle();
        wb(1, 11, 'hB0B0);
        mc(1, 12, 'hC0C0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (mcg_last) mc(1, 13 + i, 'hC0C0 + i);
        end

        // WAW with a same-cycle MC grant
        do_reset();
        issue(1, 0, 0, 0, 1, 5, 1); cycle();
        issue(1, 0, 0, 0, 1, 5, 0); mc(1, 5, 'h5555); cycle();
        mc(0, 0, 0);                                  cycle();
        issue(1, 5, 0, 0, 0, 0, 0);                   cycle();
        chk("waw_reset_pending", bus.stall, 1);

        // reset mid-stream
        do_reset();
        issue(1, 0, 0, 0, 1, 6, 0); cycle();
        issue(1, 0, 0, 0, 1, 7, 0); cycle();
        idle(); wb(1, 6, 'h66); rst = 1; cycle();
        rst = 0; idle(); issue(1, 7, 0, 0, 0, 0, 0); cycle();
        chk("post_reset_rw", bus.RegWrite, 0);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (mc_on && mcg_last) begin
                mc_on = 0;
                mc(0, 0, 0);
            end
            if (!mc_on && $urandom_range(0, 3) == 0) begin
                mc_on = 1;
                mc(1, int'($urandom_range(0, 7)), int'($urandom));
            end
            if (!wbh_last)
                wb($urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 7)), int'($urandom));
            issue($urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 79) == 0);
            if (rst) begin
                mc_on = 0;
                mc(0, 0, 0);
                wb(0, 0, 0);
            end
            cycle();
            rst = 0;
            if (rst == 0 && !mc_on) mc(0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
